// File: rtl/edge_det_pkg.sv
// Shared types and constants for the edge-detect pixel address generators.
package edge_det_pkg;

    localparam int DEFAULT_DIMWIDTH = 16;
    localparam int MIN_DIM          = 3;
    localparam int FILTER_BORDER    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y position counter: x wraps at x_limit-1 and carries into y.
module raster_counter
    import edge_det_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DIMWIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] x_limit,
    input  logic [WIDTH-1:0] y_limit,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             last
);

    logic x_wrap;

    assign x_wrap = (x == x_limit - WIDTH'(1));
    assign last   = x_wrap && (y == y_limit - WIDTH'(1));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x_wrap) begin
                x <= '0;
                y <= y + WIDTH'(1);
            end else begin
                x <= x + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/pixel_stream_addr_gen.sv
// Raster read-address and credit-gated interior write-address generator for the 3x3 filter.
// Optional stall counter output enabled by defining PIXEL_STREAM_ADDR_GEN_PERF_EN.
module pixel_stream_addr_gen
    import edge_det_pkg::*;
#(
    parameter int BUSWIDTH = 32,
    parameter int DIMWIDTH = DEFAULT_DIMWIDTH
) (
    input  logic                ahb_hclk,
    input  logic                n_rst,
    input  logic                final_enable,
    input  logic [BUSWIDTH-1:0] width,
    input  logic [BUSWIDTH-1:0] height,
    input  logic [BUSWIDTH-1:0] readStartAddress,
    input  logic [BUSWIDTH-1:0] writeStartAddress,
    output logic [BUSWIDTH-1:0] rd_addr,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [BUSWIDTH-1:0] wr_addr,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
`ifdef PIXEL_STREAM_ADDR_GEN_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int CW = 2 * DIMWIDTH;

    state_t              state, state_next;
    logic                prev_en, kick, load, cfg_bad;
    logic [DIMWIDTH-1:0] w_dim, h_dim, wr_x_limit, wr_y_limit;
    logic [DIMWIDTH-1:0] rx, ry, wx, wy;
    logic                rd_last, wr_last, rd_fin, wr_fin, rd_end, wr_end;
    logic                rd_fire, wr_fire, credit_inc;
    logic [CW-1:0]       credit;
    logic                unused_wr_pos;

    assign kick    = final_enable && !prev_en;
    assign load    = (state == ST_LOAD);
    assign cfg_bad = ((width >> DIMWIDTH) != '0) || ((height >> DIMWIDTH) != '0)
                  || (width[DIMWIDTH-1:0] < DIMWIDTH'(MIN_DIM))
                  || (height[DIMWIDTH-1:0] < DIMWIDTH'(MIN_DIM));

    assign rd_valid = (state == ST_RUN) && !rd_fin;
    assign wr_valid = (state == ST_RUN) && !wr_fin && (credit != '0);
    assign rd_fire  = rd_valid && rd_ready;
    assign wr_fire  = wr_valid && wr_ready;

    // A read completes a 3x3 window only once it reaches the interior corner of that window.
    assign credit_inc = rd_fire && (rx >= DIMWIDTH'(FILTER_BORDER)) && (ry >= DIMWIDTH'(FILTER_BORDER));
    assign rd_end     = rd_fin || (rd_fire && rd_last);
    assign wr_end     = wr_fin || (wr_fire && wr_last);

    assign wr_x_limit    = w_dim - DIMWIDTH'(FILTER_BORDER);
    assign wr_y_limit    = h_dim - DIMWIDTH'(FILTER_BORDER);
    assign unused_wr_pos = ^{wx, wy};

    raster_counter #(.WIDTH(DIMWIDTH)) u_rd_cnt (
        .clk     (ahb_hclk),
        .rst_n   (n_rst),
        .clear   (load),
        .inc     (rd_fire),
        .x_limit (w_dim),
        .y_limit (h_dim),
        .x       (rx),
        .y       (ry),
        .last    (rd_last)
    );

    raster_counter #(.WIDTH(DIMWIDTH)) u_wr_cnt (
        .clk     (ahb_hclk),
        .rst_n   (n_rst),
        .clear   (load),
        .inc     (wr_fire),
        .x_limit (wr_x_limit),
        .y_limit (wr_y_limit),
        .x       (wx),
        .y       (wy),
        .last    (wr_last)
    );

    always_ff @(posedge ahb_hclk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        cfg_err    = 1'b0;
        case (state)
            ST_IDLE: if (kick) state_next = ST_LOAD;
            ST_LOAD: begin
                busy       = 1'b1;
                state_next = cfg_bad ? ST_ERR : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (rd_end && wr_end) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                cfg_err = 1'b1;
                if (kick) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ahb_hclk or negedge n_rst) begin
        if (!n_rst) begin
            prev_en <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            w_dim   <= '0;
            h_dim   <= '0;
            credit  <= '0;
            rd_fin  <= 1'b0;
            wr_fin  <= 1'b0;
        end else begin
            prev_en <= final_enable;
            if (load) begin
                rd_addr <= readStartAddress;
                wr_addr <= writeStartAddress;
                w_dim   <= width[DIMWIDTH-1:0];
                h_dim   <= height[DIMWIDTH-1:0];
                credit  <= '0;
                rd_fin  <= 1'b0;
                wr_fin  <= 1'b0;
            end else begin
                if (rd_fire) begin
                    rd_addr <= rd_addr + BUSWIDTH'(1);
                    if (rd_last) rd_fin <= 1'b1;
                end
                if (wr_fire) begin
                    wr_addr <= wr_addr + BUSWIDTH'(1);
                    if (wr_last) wr_fin <= 1'b1;
                end
                case ({credit_inc, wr_fire})
                    2'b10:   credit <= credit + CW'(1);
                    2'b01:   credit <= credit - CW'(1);
                    default: credit <= credit;
                endcase
            end
        end
    end

`ifdef PIXEL_STREAM_ADDR_GEN_PERF_EN
    logic stall;

    assign stall = (state == ST_RUN) && ((rd_valid && !rd_ready) || (wr_valid && !wr_ready));

    always_ff @(posedge ahb_hclk or negedge n_rst) begin
        if (!n_rst) begin
            perf_stall_cnt <= '0;
        end else if (load) begin
            perf_stall_cnt <= '0;
        end else if (stall && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_stream_addr_gen.sv
// Scoreboard bench for pixel_stream_addr_gen: expected address streams and write gating
// are derived from image geometry; a negedge monitor compares every accepted transfer.
module tb_pixel_stream_addr_gen;

    localparam int BW = 32;

    logic          ahb_hclk = 1'b0;
    logic          n_rst = 1'b0;
    logic          final_enable = 1'b0;
    logic [BW-1:0] width = '0, height = '0, readStartAddress = '0, writeStartAddress = '0;
    logic          rd_ready = 1'b0, wr_ready = 1'b0;
    logic [BW-1:0] rd_addr, wr_addr;
    logic          rd_valid, wr_valid, busy, done, cfg_err;
`ifdef PIXEL_STREAM_ADDR_GEN_PERF_EN
    logic [31:0]   perf_stall_cnt;
`endif

    int checks = 0, errors = 0, cyc = 0;
    logic rand_rdy = 1'b0, rd_ready_set = 1'b1, wr_ready_set = 1'b1;

    logic [BW-1:0] rd_exp[$], wr_exp[$];
    int            wr_idx[$];
    int            rd_acc = 0, last_wr_cyc = -10;
    logic          rd_stall_q = 1'b0, wr_stall_q = 1'b0;
    logic [BW-1:0] rd_hold = '0, wr_hold = '0;

    pixel_stream_addr_gen dut (
        .ahb_hclk          (ahb_hclk),
        .n_rst             (n_rst),
        .final_enable      (final_enable),
        .width             (width),
        .height            (height),
        .readStartAddress  (readStartAddress),
        .writeStartAddress (writeStartAddress),
        .rd_addr           (rd_addr),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .wr_addr           (wr_addr),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .busy              (busy),
        .done              (done),
        .cfg_err           (cfg_err)
`ifdef PIXEL_STREAM_ADDR_GEN_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    always #5 ahb_hclk = ~ahb_hclk;
    always @(posedge ahb_hclk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: applied shortly after each rising edge.
    always @(posedge ahb_hclk) begin
        #2;
        if (rand_rdy) begin
            rd_ready = ($urandom_range(0, 3) != 0);
            wr_ready = ($urandom_range(0, 2) != 0);
        end else begin
            rd_ready = rd_ready_set;
            wr_ready = wr_ready_set;
        end
    end

    // Monitor: transfers seen valid&&ready here are accepted at the next rising edge.
    always @(negedge ahb_hclk) begin
        if (!n_rst) begin
            rd_stall_q = 1'b0;
            wr_stall_q = 1'b0;
        end else begin
            if (rd_stall_q) begin
                check("rd_hold_valid", BW'(rd_valid), 1);
                check("rd_hold_addr", rd_addr, rd_hold);
            end
            if (wr_stall_q) begin
                check("wr_hold_valid", BW'(wr_valid), 1);
                check("wr_hold_addr", wr_addr, wr_hold);
            end
            // A write may be offered only once every pixel of its 3x3 window has been read.
            check("wr_valid_gate", BW'(wr_valid),
                  BW'((wr_idx.size() != 0) && (rd_acc > wr_idx[0])));
            if (rd_valid && rd_ready) begin
                if (rd_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got read %h, none expected", rd_addr);
                end else begin
                    check("rd_addr", rd_addr, rd_exp.pop_front());
                end
                rd_acc++;
            end
            if (wr_valid && wr_ready) begin
                if (wr_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got write %h, none expected", wr_addr);
                end else begin
                    check("wr_addr", wr_addr, wr_exp.pop_front());
                    void'(wr_idx.pop_front());
                    if (wr_exp.size() == 0) last_wr_cyc = cyc;
                end
            end
            rd_stall_q = rd_valid && !rd_ready;
            rd_hold    = rd_addr;
            wr_stall_q = wr_valid && !wr_ready;
            wr_hold    = wr_addr;
        end
    end

    // Apply config and build the expected streams from the image geometry.
    task automatic setup(input int w, input int h, input logic [BW-1:0] rs,
                         input logic [BW-1:0] ws, input bit expect_run);
        width             = BW'(w);
        height            = BW'(h);
        readStartAddress  = rs;
        writeStartAddress = ws;
        rd_exp.delete();
        wr_exp.delete();
        wr_idx.delete();
        rd_acc = 0;
        if (expect_run) begin
            for (int i = 0; i < w * h; i++) rd_exp.push_back(rs + BW'(i));
            for (int j = 0; j < (w - 2) * (h - 2); j++) begin
                wr_exp.push_back(ws + BW'(j));
                wr_idx.push_back((j / (w - 2) + 2) * w + (j % (w - 2)) + 2);
            end
        end
    endtask

    task automatic check_reset_values();
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_valid", BW'(rd_valid), 0);
        check("rst_wr_valid", BW'(wr_valid), 0);
        check("rst_busy", BW'(busy), 0);
        check("rst_done", BW'(done), 0);
        check("rst_cfg_err", BW'(cfg_err), 0);
    endtask

    // Checks LOAD one cycle after the sampled edge and the first RUN (or ERR) cycle after that.
    task automatic check_start(input bit expect_err, input logic [BW-1:0] rs);
        @(negedge ahb_hclk);
        @(negedge ahb_hclk);
        check("load_busy", BW'(busy), 1);
        check("load_rd_valid", BW'(rd_valid), 0);
        check("load_cfg_err", BW'(cfg_err), 0);
        @(negedge ahb_hclk);
        if (expect_err) begin
            check("err_cfg_err", BW'(cfg_err), 1);
            check("err_busy", BW'(busy), 0);
            check("err_rd_valid", BW'(rd_valid), 0);
        end else begin
            check("kick_rd_valid", BW'(rd_valid), 1);
            check("kick_rd_addr", rd_addr, rs);
            check("kick_busy", BW'(busy), 1);
        end
    endtask

    task automatic kick(input bit expect_err, input logic [BW-1:0] rs);
        @(posedge ahb_hclk);
        #1 final_enable = 1'b0;
        @(posedge ahb_hclk);
        #1 final_enable = 1'b1;
        check_start(expect_err, rs);
        // Config and enable changes after LOAD must not disturb the run.
        width             = $urandom;
        height            = $urandom;
        readStartAddress  = $urandom;
        writeStartAddress = $urandom;
        final_enable      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge ahb_hclk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles, %0d reads %0d writes left",
                     budget, rd_exp.size(), wr_exp.size());
        end else begin
            check("done_after_last_wr", BW'(cyc), BW'(last_wr_cyc + 1));
            check("done_busy", BW'(busy), 0);
            check("done_rd_left", BW'(rd_exp.size()), 0);
            check("done_wr_left", BW'(wr_exp.size()), 0);
            @(negedge ahb_hclk);
            check("done_pulse", BW'(done), 0);
            check("idle_busy", BW'(busy), 0);
        end
    endtask

    task automatic wait_reads_done(input int budget);
        int n = 0;
        while (rd_exp.size() != 0 && n < budget) begin
            @(negedge ahb_hclk);
            n++;
        end
        if (rd_exp.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL reads_timeout: %0d reads outstanding", rd_exp.size());
        end
    endtask

    initial begin
        int w, h, n;
        repeat (3) @(posedge ahb_hclk);
        #1 check_reset_values();
        n_rst = 1'b1;

        // 4x4 basic run with ready held high.
        setup(4, 4, 32'h1000, 32'h2000, 1'b1);
        kick(1'b0, 32'h1000);
        wait_done(200);

        // Undersized width, then oversized width bit, then recovery with a 3x3 image.
        setup(2, 5, 32'h1000, 32'h2000, 1'b0);
        kick(1'b1, 32'h1000);
        repeat (4) @(negedge ahb_hclk);
        check("err_sticky", BW'(cfg_err), 1);
        check("err_no_read", BW'(rd_valid), 0);
        setup(4, 4, 32'h1000, 32'h2000, 1'b0);
        width = 32'h0001_0004;
        kick(1'b1, 32'h1000);
        setup(3, 3, 32'h0, 32'h2000, 1'b1);
        kick(1'b0, 32'h0);
        wait_done(200);

        // 5x5 with writes blocked until every read is done.
        wr_ready_set = 1'b0;
        setup(5, 5, 32'h4000, 32'h5000, 1'b1);
        kick(1'b0, 32'h4000);
        wait_reads_done(200);
        repeat (4) @(negedge ahb_hclk);
        check("blocked_done", BW'(done), 0);
        check("blocked_busy", BW'(busy), 1);
        check("blocked_wr_valid", BW'(wr_valid), 1);
        check("blocked_pending", BW'(wr_exp.size()), 9);
        wr_ready_set = 1'b1;
        wait_done(200);

        // 6x4 under random back-pressure.
        rand_rdy = 1'b1;
        setup(6, 4, 32'h6000, 32'h7000, 1'b1);
        kick(1'b0, 32'h6000);
        wait_done(1000);

        // Read address wrapping through zero.
        rand_rdy = 1'b0;
        setup(3, 3, 32'hFFFF_FFFE, 32'h3000, 1'b1);
        kick(1'b0, 32'hFFFF_FFFE);
        wait_done(200);

        // Random geometry, addresses and back-pressure.
        rand_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            w = int'($urandom_range(3, 8));
            h = int'($urandom_range(3, 6));
            setup(w, h, $urandom, $urandom, 1'b1);
            kick(1'b0, readStartAddress);
            wait_done(2000);
        end

        // Reset mid-run, then a restart inferred from enable held high across reset.
        rand_rdy = 1'b0;
        setup(4, 4, 32'h1000, 32'h2000, 1'b1);
        kick(1'b0, 32'h1000);
        n = 0;
        while (rd_acc < 7 && n < 100) begin
            @(negedge ahb_hclk);
            #1 n++;
        end
        check("reset_reads_seen", BW'(rd_acc >= 7), 1);
        n_rst = 1'b0;
        final_enable = 1'b1;
        #1 check_reset_values();
        setup(4, 4, 32'h1000, 32'h2000, 1'b1);
        @(posedge ahb_hclk);
        #1 n_rst = 1'b1;
        check_start(1'b0, 32'h1000);
        wait_done(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
